seq_detector_prog: RTL and testbench

Runtime-programmable serial bit-pattern detector. Patterns are 1 to MAX_LEN bits long, and overlap or non-overlap matching is selectable at runtime. It generalises the team's fixed 1101 Moore detectors. It adds input-valid qualification, a registered Moore detect pulse and a saturating hit counter. It sits on serial receive paths ahead of framing/sync logic.

---
 rtl/seq_det_pkg.sv | 22 ++
 rtl/seq_det_hit_counter.sv | 44 ++++
 rtl/seq_detector_prog.sv | 127 ++++++++++++
 tb/tb_seq_detector_prog.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg
// Shared definitions for the programmable serial pattern detector:
//   - state_e     : detector FSM state encoding (OFF / FILL / ARMED)
//   - len_width() : width of a length field able to hold 0..max_len
//   - clamp_len() : limits a requested pattern length to max_len
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_FILL  = 2'd1,
    ST_ARMED = 2'd2
  } state_e;

  function automatic int len_width(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_det_hit_counter.sv
// seq_det_hit_counter
// Saturating match counter with a sticky saturation flag. Clear has priority
// over increment, so a hit coinciding with a clear is not counted.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_inc      : count one hit this cycle
//   i_clr      : clear count and saturation flag
//   o_count    : hits since last clear/reset (stops at all-ones)
//   o_sat      : set once the count reaches all-ones
module seq_det_hit_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat
);

  localparam logic [CNT_W-1:0] MAX_CNT = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;
  logic             r_sat;

  // Count register and sticky saturation flag
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_inc && (r_count != MAX_CNT)) begin
      r_count <= r_count + CNT_W'(1);
      // flag rises together with the increment that lands on all-ones
      r_sat   <= r_sat | (r_count == (MAX_CNT - CNT_W'(1)));
    end else begin
      r_count <= r_count;
      r_sat   <= r_sat;
    end
  end

  assign o_count = r_count;
  assign o_sat   = r_sat;

endmodule

// File: rtl/seq_detector_prog.sv
// seq_detector_prog
// Runtime-programmable serial bit-pattern detector (1..MAX_LEN bits) with
// selectable overlapping / non-overlapping matching, valid-qualified input,
// a registered one-cycle detect pulse and a saturating hit counter.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_cfg_load      : latch i_cfg_* and flush the bit history
//   i_cfg_pattern   : pattern, LSB-aligned, bit[len-1] received first
//   i_cfg_len       : pattern length (0 = off, >MAX_LEN clamped)
//   i_cfg_overlap   : 1 = overlapping matches allowed
//   i_cnt_clr       : clear hit counter and saturation flag
//   i_in_valid      : i_in_bit is sampled this cycle
//   i_in_bit        : serial data
//   o_detect        : one-cycle pulse the cycle after a completing bit
//   o_state         : FSM state (seq_det_pkg::state_e encoding)
//   o_hit_count     : matches since last clear/reset
//   o_hit_sat       : sticky, hit count reached all-ones
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b0000_1101),
  parameter int                 RST_LEN     = 4,
  parameter logic               RST_OVERLAP = 1'b0,
  localparam int                LEN_W       = len_width(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_cfg_load,
  input  logic [MAX_LEN-1:0] i_cfg_pattern,
  input  logic [LEN_W-1:0]   i_cfg_len,
  input  logic               i_cfg_overlap,
  input  logic               i_cnt_clr,
  input  logic               i_in_valid,
  input  logic               i_in_bit,
  output logic               o_detect,
  output logic [1:0]         o_state,
  output logic [CNT_W-1:0]   o_hit_count,
  output logic               o_hit_sat
);

  localparam logic [LEN_W-1:0] RST_LEN_C = LEN_W'(clamp_len(RST_LEN, MAX_LEN));

  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic               r_overlap;
  logic [MAX_LEN-1:0] r_history;
  logic [LEN_W-1:0]   r_fill;
  logic               r_detect;
  state_e             r_state;

  logic [LEN_W-1:0]   w_cfg_len;
  logic [MAX_LEN-1:0] w_hist_n;
  logic [LEN_W-1:0]   w_fill_n;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_match;
  logic               w_accept;
  state_e             w_state_n;

  // Next history/fill for an accepted bit, match check and next state
  always_comb begin
    w_cfg_len = LEN_W'(clamp_len(int'(i_cfg_len), MAX_LEN));
    w_hist_n  = {r_history[MAX_LEN-2:0], i_in_bit};
    w_fill_n  = (r_fill < r_len) ? (r_fill + LEN_W'(1)) : r_len;
    for (int k = 0; k < MAX_LEN; k++) begin
      w_mask[k] = (k < int'(r_len));
    end
    // len==0 would trivially compare equal, so it is excluded explicitly
    w_match  = (r_len != '0) && (w_fill_n == r_len) &&
               ((w_hist_n & w_mask) == (r_pattern & w_mask));
    w_accept = i_in_valid && !i_cfg_load;
    if (r_len == '0) begin
      w_state_n = ST_OFF;
    end else if (w_match && !r_overlap) begin
      w_state_n = ST_FILL;
    end else if (w_fill_n == r_len) begin
      w_state_n = ST_ARMED;
    end else begin
      w_state_n = ST_FILL;
    end
  end

  // Configuration, shift history, fill level, detect pulse and FSM state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pattern <= RST_PATTERN;
      r_len     <= RST_LEN_C;
      r_overlap <= RST_OVERLAP;
      r_history <= '0;
      r_fill    <= '0;
      r_detect  <= 1'b0;
      r_state   <= (RST_LEN_C == '0) ? ST_OFF : ST_FILL;
    end else if (i_cfg_load) begin
      // a bit arriving with the load strobe is dropped
      r_pattern <= i_cfg_pattern;
      r_len     <= w_cfg_len;
      r_overlap <= i_cfg_overlap;
      r_history <= '0;
      r_fill    <= '0;
      r_detect  <= 1'b0;
      r_state   <= (w_cfg_len == '0) ? ST_OFF : ST_FILL;
    end else if (i_in_valid) begin
      r_history <= w_hist_n;
      r_detect  <= w_match;
      r_fill    <= (w_match && !r_overlap) ? '0 : w_fill_n;
      r_state   <= w_state_n;
    end else begin
      r_detect  <= 1'b0;
    end
  end

  seq_det_hit_counter #(
    .CNT_W (CNT_W)
  ) u_hit_counter (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_accept && w_match),
    .i_clr   (i_cnt_clr),
    .o_count (o_hit_count),
    .o_sat   (o_hit_sat)
  );

  assign o_detect = r_detect;
  assign o_state  = r_state;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Self-checking bench for seq_detector_prog. Two instances share stimulus:
// dut_a with default parameters and dut_b with a 2-bit hit counter. A
// queue-based reference model keeps the bits received since the last flush.
module tb_seq_detector_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       cnt_clr;
  logic       in_valid;
  logic       in_bit;

  logic        a_detect, b_detect, a_sat, b_sat;
  logic [1:0]  a_state, b_state;
  logic [15:0] a_count;
  logic [1:0]  b_count;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  int         m_q[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_det;
  int         m_state;
  int         m_cnt_a, m_cnt_b;
  bit         m_sat_a, m_sat_b;

  always #5 clk = ~clk;

  seq_detector_prog dut_a (
    .clk(clk), .rst(rst), .i_cfg_load(cfg_load), .i_cfg_pattern(cfg_pattern),
    .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap), .i_cnt_clr(cnt_clr),
    .i_in_valid(in_valid), .i_in_bit(in_bit), .o_detect(a_detect),
    .o_state(a_state), .o_hit_count(a_count), .o_hit_sat(a_sat)
  );

  seq_detector_prog #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .i_cfg_load(cfg_load), .i_cfg_pattern(cfg_pattern),
    .i_cfg_len(cfg_len), .i_cfg_overlap(cfg_overlap), .i_cnt_clr(cnt_clr),
    .i_in_valid(in_valid), .i_in_bit(in_bit), .o_detect(b_detect),
    .o_state(b_state), .o_hit_count(b_count), .o_hit_sat(b_sat)
  );

  // Apply current inputs to the model, then advance one clock
  task automatic tick();
    bit match;
    int n;
    match = 1'b0;
    if (rst) begin
      m_pat = 8'h0D; m_len = 4; m_ovl = 1'b0; m_q.delete();
      m_cnt_a = 0; m_cnt_b = 0; m_sat_a = 1'b0; m_sat_b = 1'b0;
    end else begin
      if (cfg_load) begin
        m_pat = cfg_pattern;
        m_len = (int'(cfg_len) > 8) ? 8 : int'(cfg_len);
        m_ovl = cfg_overlap;
        m_q.delete();
      end else if (in_valid) begin
        m_q.push_back(int'(in_bit));
        if (m_q.size() > m_len) void'(m_q.pop_front());
        n = m_q.size();
        if (m_len > 0 && n >= m_len) begin
          match = 1'b1;
          for (int k = 0; k < m_len; k++)
            if (m_q[n - m_len + k] != int'(m_pat[m_len - 1 - k])) match = 1'b0;
        end
        if (match && !m_ovl) m_q.delete();
      end
      if (cnt_clr) begin
        m_cnt_a = 0; m_cnt_b = 0; m_sat_a = 1'b0; m_sat_b = 1'b0;
      end else if (match) begin
        if (m_cnt_a < 65535) m_cnt_a++;
        if (m_cnt_a == 65535) m_sat_a = 1'b1;
        if (m_cnt_b < 3) m_cnt_b++;
        if (m_cnt_b == 3) m_sat_b = 1'b1;
      end
    end
    m_det   = match;
    m_state = (m_len == 0) ? 0 : ((m_q.size() >= m_len) ? 2 : 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    idle();
    cfg_load = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ovl;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic send(input logic b);
    in_valid = 1'b1; in_bit = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_tests++;
    if (a_detect !== 1'b0 || a_state !== 2'd1 || a_count !== 16'd0 || a_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: got det=%0b st=%0d cnt=%0d sat=%0b exp det=0 st=1 cnt=0 sat=0",
               a_detect, a_state, a_count, a_sat);
    end
  endtask

  task automatic test_non_overlap();
    logic [6:0] stream = 7'b1101101;   // bit 6 sent first
    logic [6:0] exp_det = 7'b0001000;  // index i = bit number i+1
    idle();
    for (int i = 0; i < 7; i++) begin
      send(stream[6 - i]);
      n_tests++;
      if (a_detect !== exp_det[i] || a_detect !== m_det || a_state !== 2'(m_state)) begin
        n_fail++;
        $display("FAIL non_overlap bit%0d: got det=%0b st=%0d exp det=%0b st=%0d",
                 i + 1, a_detect, a_state, exp_det[i], m_state);
      end
    end
    n_tests++;
    if (a_count !== 16'd1) begin
      n_fail++; $display("FAIL non_overlap_count: got %0d exp 1", a_count);
    end
  endtask

  task automatic test_overlap();
    logic [6:0] stream = 7'b1101101;
    logic [6:0] exp_det = 7'b1001000;
    load_cfg(8'b0000_1101, 4'd4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      send(stream[6 - i]);
      n_tests++;
      if (a_detect !== exp_det[i] || a_state !== 2'(m_state)) begin
        n_fail++;
        $display("FAIL overlap bit%0d: got det=%0b st=%0d exp det=%0b st=%0d",
                 i + 1, a_detect, a_state, exp_det[i], m_state);
      end
    end
    n_tests++;
    if (a_count !== 16'd3) begin
      n_fail++; $display("FAIL overlap_count: got %0d exp 3", a_count);
    end
  endtask

  task automatic test_gaps();
    load_cfg(8'b0000_0101, 4'd3, 1'b0);
    send(1'b1); send(1'b0);
    in_bit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (a_detect !== 1'b0) begin
        n_fail++; $display("FAIL gap_idle%0d: got det=%0b exp 0", i, a_detect);
      end
    end
    send(1'b1);
    n_tests++;
    if (a_detect !== 1'b1) begin
      n_fail++; $display("FAIL gap_match: got det=%0b exp 1", a_detect);
    end
    tick();
    n_tests++;
    if (a_detect !== 1'b0) begin
      n_fail++; $display("FAIL gap_pulse_width: got det=%0b exp 0", a_detect);
    end
  endtask

  task automatic test_cfg_mid();
    logic [3:0] stream = 4'b1101;
    load_cfg(8'b0000_1101, 4'd4, 1'b0);
    send(1'b1); send(1'b1); send(1'b0);
    // load collides with the bit that would have completed 1101
    cfg_load = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick();
    idle();
    n_tests++;
    if (a_detect !== 1'b0 || a_state !== 2'd1) begin
      n_fail++; $display("FAIL cfg_collide: got det=%0b st=%0d exp det=0 st=1", a_detect, a_state);
    end
    for (int i = 0; i < 4; i++) begin
      send(stream[3 - i]);
      n_tests++;
      if (a_detect !== ((i == 3) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL cfg_refill bit%0d: got det=%0b exp %0b", i + 1, a_detect, i == 3);
      end
    end
  endtask

  task automatic test_len_limits();
    logic [7:0] pat = 8'b1011_0011;
    load_cfg(8'b0000_0000, 4'd0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      send(1'($urandom_range(0, 1)));
      n_tests++;
      if (a_detect !== 1'b0 || a_state !== 2'd0) begin
        n_fail++; $display("FAIL len0 bit%0d: got det=%0b st=%0d exp det=0 st=0", i, a_detect, a_state);
      end
    end
    load_cfg(pat, 4'd12, 1'b0);
    for (int i = 0; i < 8; i++) begin
      send(pat[7 - i]);
      n_tests++;
      if (a_detect !== ((i == 7) ? 1'b1 : 1'b0) || a_state !== 2'(m_state)) begin
        n_fail++;
        $display("FAIL len12 bit%0d: got det=%0b st=%0d exp det=%0b st=%0d",
                 i, a_detect, a_state, i == 7, m_state);
      end
    end
  endtask

  task automatic test_counter_sat();
    int exp_cnt[5] = '{1, 2, 3, 3, 3};
    bit exp_sat[5] = '{0, 0, 1, 1, 1};
    idle(); cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    load_cfg(8'b0000_0001, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      send(1'b1);
      n_tests++;
      if (int'(b_count) !== exp_cnt[i] || b_sat !== exp_sat[i] || b_detect !== 1'b1) begin
        n_fail++;
        $display("FAIL sat hit%0d: got cnt=%0d sat=%0b det=%0b exp cnt=%0d sat=%0b det=1",
                 i + 1, b_count, b_sat, b_detect, exp_cnt[i], exp_sat[i]);
      end
    end
    cnt_clr = 1'b1; send(1'b1); cnt_clr = 1'b0;
    n_tests++;
    if (b_count !== 2'd0 || b_sat !== 1'b0 || a_count !== 16'd0 || b_detect !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_vs_match: got cnt_b=%0d sat_b=%0b cnt_a=%0d det=%0b exp 0 0 0 1",
               b_count, b_sat, a_count, b_detect);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] stream = 4'b1101;
    load_cfg(8'b0000_1101, 4'd4, 1'b1);
    send(1'b1); send(1'b1); send(1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    send(1'b1);
    n_tests++;
    if (a_detect !== 1'b0 || a_count !== 16'd0) begin
      n_fail++; $display("FAIL rst_mid: got det=%0b cnt=%0d exp det=0 cnt=0", a_detect, a_count);
    end
    send(1'b1);
    for (int i = 0; i < 4; i++) begin
      send(stream[3 - i]);
      n_tests++;
      if (a_detect !== m_det) begin
        n_fail++; $display("FAIL rst_stream bit%0d: got det=%0b exp %0b", i, a_detect, m_det);
      end
    end
    // default config is non-overlapping: trailing 101 must not re-match
    send(1'b1); send(1'b0); send(1'b1);
    n_tests++;
    if (a_detect !== 1'b0 || a_count !== 16'd1 || a_state !== 2'd1) begin
      n_fail++;
      $display("FAIL rst_defaults: got det=%0b cnt=%0d st=%0d exp det=0 cnt=1 st=1",
               a_detect, a_count, a_state);
    end
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 600; c++) begin
      idle();
      r = $urandom_range(0, 99);
      if (r < 4) begin
        cfg_load    = 1'b1;
        cfg_pattern = 8'($urandom);
        cfg_len     = ($urandom_range(0, 9) == 0) ? 4'd12 : 4'($urandom_range(0, 4));
        cfg_overlap = 1'($urandom_range(0, 1));
      end
      cnt_clr  = (r >= 4 && r < 7);
      in_valid = ($urandom_range(0, 3) != 0);
      in_bit   = 1'($urandom_range(0, 1));
      tick();
      n_tests++;
      if (a_detect !== m_det || b_detect !== m_det || a_state !== 2'(m_state) ||
          b_state !== 2'(m_state) || int'(a_count) !== m_cnt_a ||
          int'(b_count) !== m_cnt_b || a_sat !== m_sat_a || b_sat !== m_sat_b) begin
        n_fail++;
        $display("FAIL random cyc%0d: got det=%0b/%0b st=%0d cnt=%0d/%0d sat=%0b/%0b exp det=%0b st=%0d cnt=%0d/%0d sat=%0b/%0b",
                 c, a_detect, b_detect, a_state, a_count, b_count, a_sat, b_sat,
                 m_det, m_state, m_cnt_a, m_cnt_b, m_sat_a, m_sat_b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_non_overlap();
    test_overlap();
    test_gaps();
    test_cfg_mid();
    test_len_limits();
    test_counter_sat();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
